// File: rtl/matrix_arb_pkg.sv
// Shared constants, FSM encoding and dimension helpers for matrix_store_arbiter.
package matrix_arb_pkg;

  localparam int MAX_DIM_DEF = 5;

  localparam logic [1:0] REQ_W0   = 2'd0;
  localparam logic [1:0] REQ_W1   = 2'd1;
  localparam logic [1:0] REQ_R0   = 2'd2;
  localparam logic [1:0] REQ_NONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_COOL   = 2'd2
  } arb_state_t;

  // Flat table index for a (row, col) pair; only meaningful for legal dimensions.
  function automatic int dim_index(input logic [2:0] row, input logic [2:0] col,
                                   input int max_dim);
    return (int'(row) - 1) * max_dim + (int'(col) - 1);
  endfunction

  function automatic logic dim_legal(input logic [2:0] v, input int max_dim);
    return (v != 3'd0) && (int'(v) <= max_dim);
  endfunction

endpackage

// File: rtl/matrix_store_arbiter_rr_arb3.sv
// Three-input round-robin arbiter: priority starts at the requester after 'last'.
module rr_arb3
  import matrix_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  input  logic       adv,
  output logic [2:0] gnt,
  output logic [1:0] win
);

  logic [1:0] cand;

  always_comb begin
    gnt  = '0;
    win  = REQ_NONE;
    cand = REQ_W0;
    for (int k = 1; k <= 3; k++) begin
      cand = 2'((int'(last) + k) % 3);
      if (req[cand] && (win == REQ_NONE)) win = cand;
    end
    if (adv) begin
      case (win)
        REQ_W0:  gnt = 3'b001;
        REQ_W1:  gnt = 3'b010;
        REQ_R0:  gnt = 3'b100;
        default: gnt = 3'b000;
      endcase
    end
  end

endmodule

// File: rtl/matrix_store_arbiter.sv
// Arbitrates the single matrix-storage port between two writers and one reader and
// allocates write slots per dimension. Optional total_stored output: MATRIX_ARB_STATS_EN.
module matrix_store_arbiter
  import matrix_arb_pkg::*;
#(
  parameter int MAX_DIM       = MAX_DIM_DEF,
  parameter int SLOTS_PER_DIM = 2,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       w0_req,
  input  logic [2:0] w0_row,
  input  logic [2:0] w0_col,
  output logic       w0_gnt,
  input  logic       w1_req,
  input  logic [2:0] w1_row,
  input  logic [2:0] w1_col,
  output logic       w1_gnt,
  input  logic       r0_req,
  input  logic [2:0] r0_row,
  input  logic [2:0] r0_col,
  input  logic [2:0] r0_slot,
  output logic       r0_gnt,
  output logic       err,
  output logic       st_wr_en,
  output logic       st_rd_en,
  output logic [2:0] st_row,
  output logic [2:0] st_col,
  output logic [2:0] st_slot,
  output logic [1:0] sel,
  output logic       busy
`ifdef MATRIX_ARB_STATS_EN
 ,output logic [$clog2(MAX_DIM*MAX_DIM*SLOTS_PER_DIM+1)-1:0] total_stored
`endif
);

  localparam int NDIM = MAX_DIM * MAX_DIM;
  localparam int DW   = (NDIM > 1) ? $clog2(NDIM) : 1;
  localparam int CW   = $clog2(SLOTS_PER_DIM + 1);
  localparam int NW   = (SLOTS_PER_DIM > 1) ? $clog2(SLOTS_PER_DIM) : 1;
  localparam int KW   = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  arb_state_t    state_q, state_d;
  logic [1:0]    last_win;
  logic [1:0]    sel_q;
  logic [KW-1:0] cool_cnt;
  logic [2:0]    lat_row, lat_col, lat_slot;
  logic          lat_rd, lat_ok;
  logic [DW-1:0] lat_d;

  logic [CW-1:0] cnt_tab [NDIM];
  logic [NW-1:0] nxt_tab [NDIM];

  logic [2:0]    rr_gnt;
  logic [1:0]    rr_win;
  logic          grant_any;
  logic [2:0]    win_row, win_col, win_slot;
  logic          win_rd, win_dims_ok, win_ok;
  logic [DW-1:0] win_d;
  logic          do_write;

  rr_arb3 u_rr (
    .req  ({r0_req, w1_req, w0_req}),
    .last (last_win),
    .adv  (state_q == ST_IDLE),
    .gnt  (rr_gnt),
    .win  (rr_win)
  );

  assign grant_any = |rr_gnt;

  // Legality and slot choice are settled when the winner is latched; tables cannot
  // change between IDLE and ACCESS, so the latched view stays valid.
  always_comb begin
    win_row = w0_row;
    win_col = w0_col;
    win_rd  = 1'b0;
    case (rr_win)
      REQ_W1: begin win_row = w1_row; win_col = w1_col; end
      REQ_R0: begin win_row = r0_row; win_col = r0_col; win_rd = 1'b1; end
      default: ;
    endcase
    win_dims_ok = dim_legal(win_row, MAX_DIM) && dim_legal(win_col, MAX_DIM);
    win_d       = '0;
    if (win_dims_ok) win_d = DW'(dim_index(win_row, win_col, MAX_DIM));
    win_ok   = win_dims_ok;
    win_slot = '0;
    if (win_rd) begin
      win_slot = r0_slot;
      win_ok   = win_dims_ok && (int'(r0_slot) < int'(cnt_tab[win_d]));
    end else if (win_dims_ok) begin
      win_slot = 3'(nxt_tab[win_d]);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_any) state_d = ST_ACCESS;
      ST_ACCESS: state_d = lat_ok ? ST_COOL : ST_IDLE;
      ST_COOL:   if (cool_cnt == '0) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      last_win <= REQ_R0;  // puts W0 first in line after reset
      sel_q    <= REQ_NONE;
      cool_cnt <= '0;
      lat_row  <= '0;
      lat_col  <= '0;
      lat_slot <= '0;
      lat_rd   <= 1'b0;
      lat_ok   <= 1'b0;
      lat_d    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            last_win <= rr_win;
            sel_q    <= rr_win;
            lat_row  <= win_row;
            lat_col  <= win_col;
            lat_slot <= win_slot;
            lat_rd   <= win_rd;
            lat_ok   <= win_ok;
            lat_d    <= win_d;
            cool_cnt <= KW'(ACCESS_CYCLES - 1);
          end
        end
        ST_ACCESS: if (!lat_ok) sel_q <= REQ_NONE;
        ST_COOL: begin
          if (cool_cnt == '0) sel_q <= REQ_NONE;
          else                cool_cnt <= cool_cnt - 1'b1;
        end
        default: sel_q <= REQ_NONE;
      endcase
    end
  end

  assign do_write = (state_q == ST_ACCESS) && lat_ok && !lat_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NDIM; i++) begin
        cnt_tab[i] <= '0;
        nxt_tab[i] <= '0;
      end
    end else if (do_write) begin
      if (int'(nxt_tab[lat_d]) == SLOTS_PER_DIM - 1) nxt_tab[lat_d] <= '0;
      else                                           nxt_tab[lat_d] <= nxt_tab[lat_d] + 1'b1;
      if (int'(cnt_tab[lat_d]) < SLOTS_PER_DIM) cnt_tab[lat_d] <= cnt_tab[lat_d] + 1'b1;
    end
  end

`ifdef MATRIX_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_stored <= '0;
    end else if (do_write && (int'(cnt_tab[lat_d]) < SLOTS_PER_DIM)) begin
      total_stored <= total_stored + 1'b1;
    end
  end
`endif

  assign w0_gnt   = (state_q == ST_ACCESS) && (sel_q == REQ_W0);
  assign w1_gnt   = (state_q == ST_ACCESS) && (sel_q == REQ_W1);
  assign r0_gnt   = (state_q == ST_ACCESS) && (sel_q == REQ_R0);
  assign err      = (state_q == ST_ACCESS) && !lat_ok;
  assign st_wr_en = do_write;
  assign st_rd_en = (state_q == ST_ACCESS) && lat_ok && lat_rd;
  assign st_row   = lat_row;
  assign st_col   = lat_col;
  assign st_slot  = lat_slot;
  assign sel      = sel_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
